// File: rtl/input_debounce_pkg.sv
// Shared types and helpers for the multi-bit debouncer.
// Holds the per-bit FSM state encoding and the counter sizing function.
package debounce_pkg;

   typedef enum logic {
      STABLE = 1'b0,
      VERIFY = 1'b1
   } dbnc_state_e;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/input_debounce_if.sv
// Bundle of the debouncer data and strobe signals.
// The master side drives the raw levels; the slave side is the debouncer.
interface input_debounce_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] D_I;
   logic [WIDTH-1:0] D_O;
   logic [WIDTH-1:0] RISE_O;
   logic [WIDTH-1:0] FALL_O;
   logic             CHANGE_O;

   modport master (
      output D_I,
      input  D_O,
      input  RISE_O,
      input  FALL_O,
      input  CHANGE_O
   );

   modport slave (
      input  D_I,
      output D_O,
      output RISE_O,
      output FALL_O,
      output CHANGE_O
   );
endinterface

// File: rtl/input_debounce_bit.sv
// Single-bit debouncer: two-state FSM plus run-length counter.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit
   import debounce_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic d_o,
   output logic rise_o,
   output logic fall_o,
   output logic commit_o
);
   localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   dbnc_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE: begin
            if (d_i != level_q) begin
               state_d = VERIFY;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         VERIFY: begin
            if (d_i == level_q) begin
               // Bounce back to the held level: drop the candidate silently.
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE;
               cnt_d   = '0;
               level_d = d_i;
               rise_d  = d_i;
               fall_d  = ~d_i;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         level_q <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign d_o      = level_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign commit_o = rise_d | fall_d;

endmodule

// File: rtl/input_debounce.sv
// Multi-bit debouncer and edge detector for already-synchronized inputs.
// One independent debounce_bit per input, plus a registered any-change strobe.
module input_debounce
   import debounce_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             CLK_I,
   input  logic             RSTN_I,
   input_debounce_if.slave  bus
);
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("input_debounce: DEBOUNCE_CYCLES must be >= 2");
   end

   logic [WIDTH-1:0] level_vec;
   logic [WIDTH-1:0] rise_vec;
   logic [WIDTH-1:0] fall_vec;
   logic [WIDTH-1:0] commit_vec;
   logic             change_q, change_d;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL[gi])
      ) u_bit (
         .clk_i    (CLK_I),
         .rstn_i   (RSTN_I),
         .d_i      (bus.D_I[gi]),
         .d_o      (level_vec[gi]),
         .rise_o   (rise_vec[gi]),
         .fall_o   (fall_vec[gi]),
         .commit_o (commit_vec[gi])
      );
   end

   // Built from the bits' next-cycle commits so it lines up with their strobes.
   always_comb begin
      change_d = |commit_vec;
   end

   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         change_q <= 1'b0;
      end else begin
         change_q <= change_d;
      end
   end

   assign bus.D_O      = level_vec;
   assign bus.RISE_O   = rise_vec;
   assign bus.FALL_O   = fall_vec;
   assign bus.CHANGE_O = change_q;

endmodule
